// File: rtl/traffic_pkg.sv
// Shared intersection definitions: phase and fault encodings, lamp-bus
// payload layout and the default dwell times.
// Ports: none (package).
package traffic_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned FAULT_W = 3;
  localparam int unsigned DWELL_W = 6;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [PHASE_W-1:0] {
    PH_NS_G    = 3'd0,
    PH_NS_Y    = 3'd1,
    PH_AR1     = 3'd2,
    PH_EW_G    = 3'd3,
    PH_EW_Y    = 3'd4,
    PH_AR2     = 3'd5,
    PH_UNKNOWN = 3'd7
  } phase_e;

  typedef enum logic [FAULT_W-1:0] {
    FLT_NONE     = 3'd0,
    FLT_CONFLICT = 3'd1,
    FLT_INVALID  = 3'd2,
    FLT_SEQUENCE = 3'd3,
    FLT_SHORT    = 3'd4,
    FLT_LONG     = 3'd5
  } fault_e;

  localparam logic [DWELL_W-1:0] DEF_NS_GREEN_TIME  = 6'd30;
  localparam logic [DWELL_W-1:0] DEF_NS_YELLOW_TIME = 6'd5;
  localparam logic [DWELL_W-1:0] DEF_ALL_RED1_TIME  = 6'd2;
  localparam logic [DWELL_W-1:0] DEF_EW_GREEN_TIME  = 6'd25;
  localparam logic [DWELL_W-1:0] DEF_EW_YELLOW_TIME = 6'd5;
  localparam logic [DWELL_W-1:0] DEF_ALL_RED2_TIME  = 6'd2;
  localparam logic [DWELL_W-1:0] DWELL_MAX          = 6'd63;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
  } lamps_t;

  typedef struct packed {
    logic is_nsg;
    logic is_nsy;
    logic is_ar;
    logic is_ewg;
    logic is_ewy;
    logic conflict;
    logic invalid;
  } lamp_dec_t;

  localparam lamps_t LAMPS_NSG = 6'b001100;
  localparam lamps_t LAMPS_NSY = 6'b010100;
  localparam lamps_t LAMPS_AR  = 6'b100100;
  localparam lamps_t LAMPS_EWG = 6'b100001;
  localparam lamps_t LAMPS_EWY = 6'b100010;

  // Legal successor in the fixed six-phase rotation.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_NS_G: return PH_NS_Y;
      PH_NS_Y: return PH_AR1;
      PH_AR1:  return PH_EW_G;
      PH_EW_G: return PH_EW_Y;
      PH_EW_Y: return PH_AR2;
      PH_AR2:  return PH_NS_G;
      default: return PH_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp bus plus monitor status bundle.
// master: intersection side, drives lamps and fault_clear, reads status.
// slave : monitor side, reads lamps and fault_clear, drives status.
interface traffic_light_monitor_if;
  import traffic_pkg::*;

  logic                 ns_red;
  logic                 ns_yellow;
  logic                 ns_green;
  logic                 ew_red;
  logic                 ew_yellow;
  logic                 ew_green;
  logic                 fault_clear;
  logic [PHASE_W-1:0]   phase;
  logic                 phase_known;
  logic                 fault_valid;
  logic [FAULT_W-1:0]   fault_code;
  logic                 fault_pulse;
  logic [COUNT_W-1:0]   cycle_count;

  modport master (
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, fault_clear,
    input  phase, phase_known, fault_valid, fault_code, fault_pulse, cycle_count
  );

  modport slave (
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, fault_clear,
    output phase, phase_known, fault_valid, fault_code, fault_pulse, cycle_count
  );

endinterface

// File: rtl/tl_lamp_decoder.sv
// Combinational lamp-pattern classifier.
// Ports: lamps_i - six sampled lamp lines; dec_o - one-hot phase pattern
// flags plus conflict / invalid indications.
module tl_lamp_decoder
  import traffic_pkg::*;
(
  input  lamps_t    lamps_i,
  output lamp_dec_t dec_o
);

  logic ns_lit;
  logic ew_lit;
  logic any_legal;

  always_comb begin
    ns_lit = lamps_i.ns_yellow | lamps_i.ns_green;
    ew_lit = lamps_i.ew_yellow | lamps_i.ew_green;

    dec_o.is_nsg   = (lamps_i == LAMPS_NSG);
    dec_o.is_nsy   = (lamps_i == LAMPS_NSY);
    dec_o.is_ar    = (lamps_i == LAMPS_AR);
    dec_o.is_ewg   = (lamps_i == LAMPS_EWG);
    dec_o.is_ewy   = (lamps_i == LAMPS_EWY);

    any_legal = (lamps_i == LAMPS_NSG) | (lamps_i == LAMPS_NSY) | (lamps_i == LAMPS_AR) |
                (lamps_i == LAMPS_EWG) | (lamps_i == LAMPS_EWY);

    // Crossing go/caution lamps outrank every other classification.
    dec_o.conflict = ns_lit & ew_lit;
    dec_o.invalid  = ~(ns_lit & ew_lit) & ~any_legal;
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side safety monitor for the 4-way intersection lamp bus.
// Registers the lamps, decodes them to a phase, checks phase order and dwell
// time, and keeps a sticky first-fault code.
// Ports: clk, reset (async, active-high); bus (slave modport) carries the
// six lamp lines, fault_clear, and the registered status outputs phase,
// phase_known, fault_valid, fault_code, fault_pulse, cycle_count.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter logic [DWELL_W-1:0] NS_GREEN_TIME  = DEF_NS_GREEN_TIME,
  parameter logic [DWELL_W-1:0] NS_YELLOW_TIME = DEF_NS_YELLOW_TIME,
  parameter logic [DWELL_W-1:0] ALL_RED1_TIME  = DEF_ALL_RED1_TIME,
  parameter logic [DWELL_W-1:0] EW_GREEN_TIME  = DEF_EW_GREEN_TIME,
  parameter logic [DWELL_W-1:0] EW_YELLOW_TIME = DEF_EW_YELLOW_TIME,
  parameter logic [DWELL_W-1:0] ALL_RED2_TIME  = DEF_ALL_RED2_TIME
) (
  input  logic                    clk,
  input  logic                    reset,
  traffic_light_monitor_if.slave  bus
);

  lamps_t               lamps_d, lamps_q;
  lamp_dec_t            dec;
  phase_e               phase_d, phase_q;
  phase_e               obs_phase;
  logic [DWELL_W-1:0]   dwell_d, dwell_q;
  logic                 dwell_valid_d, dwell_valid_q;
  logic [DWELL_W-1:0]   time_sel;
  logic                 fault_det;
  fault_e               fault_kind;
  logic                 fault_valid_d, fault_valid_q;
  logic [FAULT_W-1:0]   fault_code_d, fault_code_q;
  logic                 fault_pulse_d, fault_pulse_q;
  logic                 phase_known_d, phase_known_q;
  logic [COUNT_W-1:0]   cycle_count_d, cycle_count_q;

  tl_lamp_decoder u_dec (
    .lamps_i (lamps_q),
    .dec_o   (dec)
  );

  // Raw lamp sample for the input register.
  always_comb begin
    lamps_d.ns_red    = bus.ns_red;
    lamps_d.ns_yellow = bus.ns_yellow;
    lamps_d.ns_green  = bus.ns_green;
    lamps_d.ew_red    = bus.ew_red;
    lamps_d.ew_yellow = bus.ew_yellow;
    lamps_d.ew_green  = bus.ew_green;
  end

  // Observed phase; all-red is resolved by which yellow preceded it.
  // All-red straight out of a green has no defined phase and reads UNKNOWN.
  always_comb begin
    obs_phase = PH_UNKNOWN;
    if (dec.is_nsg)      obs_phase = PH_NS_G;
    else if (dec.is_nsy) obs_phase = PH_NS_Y;
    else if (dec.is_ewg) obs_phase = PH_EW_G;
    else if (dec.is_ewy) obs_phase = PH_EW_Y;
    else if (dec.is_ar) begin
      if (phase_q == PH_NS_Y || phase_q == PH_AR1)      obs_phase = PH_AR1;
      else if (phase_q == PH_EW_Y || phase_q == PH_AR2) obs_phase = PH_AR2;
    end
  end

  // Required dwell of the tracked phase.
  always_comb begin
    case (phase_q)
      PH_NS_G: time_sel = NS_GREEN_TIME;
      PH_NS_Y: time_sel = NS_YELLOW_TIME;
      PH_AR1:  time_sel = ALL_RED1_TIME;
      PH_EW_G: time_sel = EW_GREEN_TIME;
      PH_EW_Y: time_sel = EW_YELLOW_TIME;
      PH_AR2:  time_sel = ALL_RED2_TIME;
      default: time_sel = DWELL_MAX;
    endcase
  end

  // Phase tracker, dwell counter, fault latch and cycle counter next-state.
  always_comb begin
    phase_d       = phase_q;
    dwell_d       = dwell_q;
    dwell_valid_d = dwell_valid_q;
    cycle_count_d = cycle_count_q;
    fault_det     = 1'b0;
    fault_kind    = FLT_NONE;

    if (dec.conflict || dec.invalid) begin
      fault_det     = 1'b1;
      fault_kind    = dec.conflict ? FLT_CONFLICT : FLT_INVALID;
      phase_d       = PH_UNKNOWN;
      dwell_d       = DWELL_W'(1);
      dwell_valid_d = 1'b0;
    end else if (phase_q == PH_UNKNOWN) begin
      if (!dec.is_ar) begin
        phase_d       = obs_phase;
        dwell_d       = DWELL_W'(1);
        dwell_valid_d = 1'b0;
      end
    end else if (obs_phase == phase_q) begin
      // dwell only passes TIME once per visit, so LONG fires once.
      if (dwell_valid_q && dwell_q == time_sel) begin
        fault_det  = 1'b1;
        fault_kind = FLT_LONG;
      end
      if (dwell_q != DWELL_MAX) dwell_d = dwell_q + DWELL_W'(1);
    end else if (obs_phase == next_phase(phase_q)) begin
      if (dwell_valid_q && dwell_q < time_sel) begin
        fault_det  = 1'b1;
        fault_kind = FLT_SHORT;
      end
      if (phase_q == PH_AR2) cycle_count_d = cycle_count_q + COUNT_W'(1);
      phase_d       = obs_phase;
      dwell_d       = DWELL_W'(1);
      dwell_valid_d = 1'b1;
    end else begin
      fault_det     = 1'b1;
      fault_kind    = FLT_SEQUENCE;
      phase_d       = obs_phase;
      dwell_d       = DWELL_W'(1);
      dwell_valid_d = 1'b0;
    end

    fault_pulse_d = fault_det;
    fault_valid_d = fault_valid_q;
    fault_code_d  = fault_code_q;
    // A fault coincident with a clear is latched fresh.
    if (bus.fault_clear) begin
      fault_valid_d = fault_det;
      fault_code_d  = fault_det ? fault_kind : FLT_NONE;
    end else if (fault_det && !fault_valid_q) begin
      fault_valid_d = 1'b1;
      fault_code_d  = fault_kind;
    end

    phase_known_d = (phase_d != PH_UNKNOWN);
  end

  // State and output registers; lamp register resets to the NS green pattern
  // so the first evaluated sample matches the reset phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lamps_q       <= LAMPS_NSG;
      phase_q       <= PH_NS_G;
      dwell_q       <= DWELL_W'(1);
      dwell_valid_q <= 1'b0;
      cycle_count_q <= '0;
      fault_pulse_q <= 1'b0;
      fault_valid_q <= 1'b0;
      fault_code_q  <= FLT_NONE;
      phase_known_q <= 1'b1;
    end else begin
      lamps_q       <= lamps_d;
      phase_q       <= phase_d;
      dwell_q       <= dwell_d;
      dwell_valid_q <= dwell_valid_d;
      cycle_count_q <= cycle_count_d;
      fault_pulse_q <= fault_pulse_d;
      fault_valid_q <= fault_valid_d;
      fault_code_q  <= fault_code_d;
      phase_known_q <= phase_known_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.phase_known = phase_known_q;
  assign bus.fault_valid = fault_valid_q;
  assign bus.fault_code  = fault_code_q;
  assign bus.fault_pulse = fault_pulse_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus a
// randomized lamp stream, checked against a rule-level reference model.
module tb_traffic_light_monitor;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  traffic_light_monitor_if bus ();

  traffic_light_monitor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Lamp patterns, bit order {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}.
  localparam logic [5:0] P_NSG  = 6'b001100;
  localparam logic [5:0] P_NSY  = 6'b010100;
  localparam logic [5:0] P_AR   = 6'b100100;
  localparam logic [5:0] P_EWG  = 6'b100001;
  localparam logic [5:0] P_EWY  = 6'b100010;
  localparam logic [5:0] P_CONF = 6'b001001;

  int         req_time [6] = '{30, 5, 2, 25, 5, 2};
  logic [5:0] phase_pat[6] = '{P_NSG, P_NSY, P_AR, P_EWG, P_EWY, P_AR};

  int n_cmp = 0;
  int n_bad = 0;
  int pulses;

  // Reference model state.
  int         m_phase, m_dwell, m_cc, m_fc;
  bit         m_dv, m_fv, m_fp;
  logic [5:0] prev_pat;

  // 0..4 phase of a legal non-red pattern, 8 all-red, 9 conflict, 10 invalid.
  function automatic int classify(input logic [5:0] p);
    if ((p[4] | p[3]) && (p[1] | p[0])) return 9;
    case (p)
      P_NSG:   return 0;
      P_NSY:   return 1;
      P_EWG:   return 3;
      P_EWY:   return 4;
      P_AR:    return 8;
      default: return 10;
    endcase
  endfunction

  function automatic logic [5:0] ctrl_pat(input int t);
    int r;
    r = t % 69;
    if (r < 30) return P_NSG;
    if (r < 35) return P_NSY;
    if (r < 37) return P_AR;
    if (r < 62) return P_EWG;
    if (r < 67) return P_EWY;
    return P_AR;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_dwell  = 1;
    m_dv     = 1'b0;
    m_fv     = 1'b0;
    m_fc     = 0;
    m_fp     = 1'b0;
    m_cc     = 0;
    prev_pat = P_NSG;
  endtask

  task automatic model_step(input logic [5:0] p, input bit clr);
    int c, obs, kind;
    bit flt;
    flt  = 1'b0;
    kind = 0;
    c    = classify(p);
    if (c >= 9) begin
      flt = 1'b1; kind = (c == 9) ? 1 : 2;
      m_phase = 7; m_dwell = 1; m_dv = 1'b0;
    end else if (m_phase == 7) begin
      if (c != 8) begin m_phase = c; m_dwell = 1; m_dv = 1'b0; end
    end else begin
      obs = c;
      if (c == 8) begin
        if (m_phase == 1 || m_phase == 2)      obs = 2;
        else if (m_phase == 4 || m_phase == 5) obs = 5;
        else                                   obs = 7;
      end
      if (obs == m_phase) begin
        if (m_dv && m_dwell == req_time[m_phase]) begin flt = 1'b1; kind = 5; end
        if (m_dwell < 63) m_dwell = m_dwell + 1;
      end else if (obs == (m_phase + 1) % 6) begin
        if (m_dv && m_dwell < req_time[m_phase]) begin flt = 1'b1; kind = 4; end
        if (m_phase == 5) m_cc = (m_cc + 1) % 65536;
        m_phase = obs; m_dwell = 1; m_dv = 1'b1;
      end else begin
        flt = 1'b1; kind = 3;
        m_phase = obs; m_dwell = 1; m_dv = 1'b0;
      end
    end
    m_fp = flt;
    if (clr) begin
      m_fv = flt;
      m_fc = flt ? kind : 0;
    end else if (flt && !m_fv) begin
      m_fv = 1'b1;
      m_fc = kind;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("phase",       16'(bus.phase),       16'(m_phase));
    check("phase_known", 16'(bus.phase_known), 16'(m_phase != 7));
    check("fault_valid", 16'(bus.fault_valid), 16'(m_fv));
    check("fault_code",  16'(bus.fault_code),  16'(m_fc));
    check("fault_pulse", 16'(bus.fault_pulse), 16'(m_fp));
    check("cycle_count", bus.cycle_count,      16'(m_cc));
  endtask

  task automatic drive(input logic [5:0] p, input bit clr);
    {bus.ns_red, bus.ns_yellow, bus.ns_green, bus.ew_red, bus.ew_yellow, bus.ew_green} = p;
    bus.fault_clear = clr;
  endtask

  // Each edge evaluates the lamps captured one edge earlier together with
  // the fault_clear present now; outputs are checked on the falling edge.
  task automatic step(input logic [5:0] p, input bit clr);
    drive(p, clr);
    @(posedge clk);
    model_step(prev_pat, clr);
    prev_pat = p;
    @(negedge clk);
    compare_all();
    if (bus.fault_pulse) pulses++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    drive(P_NSG, 1'b0);
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int gph, gleft, sel;
    logic [5:0] p;
    bit c;

    drive(P_NSG, 1'b0);
    do_reset();

    // Three clean controller cycles.
    for (int t = 0; t < 210; t++) step(ctrl_pat(t), 1'b0);
    check("ctrl_cycles", bus.cycle_count, 16'd3);
    check("ctrl_clean",  16'(bus.fault_valid), 16'd0);

    // Conflict inside EW green, then relock.
    for (int t = 210; t <= 250; t++) step(ctrl_pat(t), 1'b0);
    step(P_CONF, 1'b0);
    step(P_EWG, 1'b0);
    check("conf_pulse", 16'(bus.fault_pulse), 16'd1);
    check("conf_code",  16'(bus.fault_code),  16'd1);
    check("conf_phase", 16'(bus.phase),       16'd7);
    step(P_EWG, 1'b0);
    check("relock_phase", 16'(bus.phase), 16'd3);

    // Short NS yellow.
    do_reset();
    repeat (30) step(P_NSG, 1'b0);
    repeat (3)  step(P_NSY, 1'b0);
    step(P_AR, 1'b0);
    step(P_AR, 1'b0);
    check("short_code", 16'(bus.fault_code), 16'd4);

    // Long NS green after a full rotation.
    do_reset();
    repeat (10) step(P_NSG, 1'b0);
    repeat (5)  step(P_NSY, 1'b0);
    repeat (2)  step(P_AR, 1'b0);
    repeat (25) step(P_EWG, 1'b0);
    repeat (5)  step(P_EWY, 1'b0);
    repeat (2)  step(P_AR, 1'b0);
    pulses = 0;
    repeat (31) step(P_NSG, 1'b0);
    check("long_not_yet", 16'(bus.fault_valid), 16'd0);
    step(P_NSG, 1'b0);
    check("long_code", 16'(bus.fault_code), 16'd5);
    repeat (4) step(P_NSG, 1'b0);
    check("long_once", 16'(pulses), 16'd1);

    // Sequence fault, clear, then clear coincident with a conflict.
    do_reset();
    repeat (5) step(P_NSG, 1'b0);
    step(P_EWG, 1'b0);
    step(P_EWG, 1'b0);
    check("seq_code", 16'(bus.fault_code), 16'd3);
    step(P_EWG, 1'b1);
    check("clr_valid", 16'(bus.fault_valid), 16'd0);
    check("clr_code",  16'(bus.fault_code),  16'd0);
    step(P_CONF, 1'b0);
    step(P_EWG, 1'b1);
    check("clr_conf_code",  16'(bus.fault_code),  16'd1);
    check("clr_conf_valid", 16'(bus.fault_valid), 16'd1);

    // Asynchronous reset in EW green; first phase afterwards is unchecked.
    do_reset();
    for (int t = 0; t < 46; t++) step(ctrl_pat(t), 1'b0);
    do_reset();
    check("rst_phase", 16'(bus.phase), 16'd0);
    repeat (5) step(P_NSG, 1'b0);
    repeat (4) step(P_NSY, 1'b0);
    check("rst_no_fault", 16'(bus.fault_valid), 16'd0);

    // Randomized stream: mostly rotation with jittered dwell, plus stray
    // patterns, phase skips and clears.
    do_reset();
    gph   = 0;
    gleft = int'($urandom_range(1, 35));
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        p = 6'($urandom_range(0, 63));
      end else begin
        p = phase_pat[gph];
        gleft--;
        if (gleft <= 0) begin
          if ($urandom_range(0, 19) == 0) gph = int'($urandom_range(0, 5));
          else                            gph = (gph + 1) % 6;
          sel   = int'($urandom_range(0, 5));
          gleft = req_time[gph] + ((sel == 0) ? -1 : (sel == 1) ? 1 : 0);
          if (gleft < 1) gleft = 1;
        end
      end
      c = ($urandom_range(0, 24) == 0);
      step(p, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
